// File: rtl/hazard_pkg.sv
// hazard_pkg: op-class encodings, forwarding selects and occupancy FSM states
package hazard_pkg;
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_ALU   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_BRJ   = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;
  typedef enum logic {S_IDLE, S_BUSY} mc_state_t;
endpackage

// File: rtl/hazard_ctrl_mc_occupancy.sv
// mc_occupancy: tracks how long a MUL/DIV has held EXE and flags its final cycle
module mc_occupancy
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] optype_EXE,
  input  logic       de_en,
  output logic       mc_stall,
  output logic       mc_done,
  output logic       mc_busy
);
  localparam int MAXL = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = MAXL > 1 ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT > 1 ? DIV_LAT - 2 : 0);
  mc_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_acc;
  logic w_mul, w_mc, w_one, w_new;
  logic [CW-1:0] w_ld;
  always_comb begin
    w_mul = optype_EXE == OP_MUL;
    w_mc = !rst && (w_mul || optype_EXE == OP_DIV);
    w_one = w_mul ? MUL_LAT == 1 : DIV_LAT == 1;
    w_ld = w_mul ? MUL_LD : DIV_LD;
    w_new = w_mc && r_state == S_IDLE && !r_acc;
    // an already-accepted op sitting in IDLE has finished, so it must not stall again
    mc_done = w_mc && (r_state == S_BUSY ? r_cnt == '0 : (r_acc || w_one));
    mc_stall = w_mc && !mc_done;
  end
  assign mc_busy = r_state == S_BUSY;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_acc <= 1'b0;
    end else begin
      r_acc <= !de_en && (r_acc || w_new);
      if (r_state == S_BUSY) begin
        if (r_cnt == '0) r_state <= S_IDLE;
        else r_cnt <= r_cnt - 1'b1;
      end else if (w_new && !w_one) begin
        r_state <= S_BUSY;
        r_cnt <= w_ld;
      end
    end
  end
endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: 5-stage pipeline forwarding, stall/flush control and perf counters
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [2:0]        optype_ID,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic [2:0]        optype_EXE,
  input  logic [2:0]        optype_MEM,
  input  logic [REG_AW-1:0] rs2_EXE,
  input  logic              redirect_EXE,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_DE_EN,
  output logic              reg_EM_EN,
  output logic              reg_MW_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic              reg_EM_flush,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic w_d1e, w_d2e, w_d1m, w_d2m, w_exe_fwd, w_mem_alu, w_mem_ld;
  logic w_ld_stall, w_mc_stall, w_mc_done, w_hold;
  mc_occupancy #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_mc (
    .clk(clk), .rst(rst), .optype_EXE(optype_EXE), .de_en(reg_DE_EN),
    .mc_stall(w_mc_stall), .mc_done(w_mc_done), .mc_busy(mc_busy)
  );
  always_comb begin
    w_d1e = rs1use_ID && rs1_ID != '0 && rs1_ID == rd_EXE;
    w_d2e = rs2use_ID && rs2_ID != '0 && rs2_ID == rd_EXE;
    w_d1m = rs1use_ID && rs1_ID != '0 && rs1_ID == rd_MEM;
    w_d2m = rs2use_ID && rs2_ID != '0 && rs2_ID == rd_MEM;
    w_exe_fwd = optype_EXE == OP_ALU || w_mc_done;
    w_mem_alu = optype_MEM inside {OP_ALU, OP_MUL, OP_DIV};
    w_mem_ld = optype_MEM == OP_LOAD;
    forward_ctrl_A = w_d1e && w_exe_fwd ? FWD_EXE : w_d1m && w_mem_alu ? FWD_MEM
                   : w_d1m && w_mem_ld ? FWD_LD : FWD_RF;
    forward_ctrl_B = w_d2e && w_exe_fwd ? FWD_EXE : w_d2m && w_mem_alu ? FWD_MEM
                   : w_d2m && w_mem_ld ? FWD_LD : FWD_RF;
    forward_ctrl_ls = optype_EXE == OP_STORE && rs2_EXE != '0 && rs2_EXE == rd_MEM && w_mem_ld;
    // store data on rs2 is patched in EXE from the load, so it needs no stall
    w_ld_stall = optype_EXE == OP_LOAD && rd_EXE != '0 && (w_d1e || (w_d2e && optype_ID != OP_STORE));
    w_hold = !redirect_EXE && (w_mc_stall || w_ld_stall);
    PC_EN_IF = !w_hold;
    reg_FD_EN = !w_hold;
    reg_DE_EN = redirect_EXE || !w_mc_stall;
    reg_EM_EN = 1'b1;
    reg_MW_EN = 1'b1;
    reg_FD_flush = redirect_EXE;
    reg_DE_flush = redirect_EXE || (!w_mc_stall && w_ld_stall);
    reg_EM_flush = !redirect_EXE && w_mc_stall;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_EN_IF && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (redirect_EXE && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed vectors checked against a cycle-age behavioural model
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic rs1use, rs2use, redir;
  logic [4:0] rs1, rs2, rde, rdm, rs2e;
  logic [2:0] opid, ope, opm;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_fl, de_fl, em_fl, fls, busy;
  logic [1:0] fa, fb;
  logic [31:0] scnt, fcnt;
  logic pc_en4, fd_en4, de_en4, em_en4, mw_en4, fd_fl4, de_fl4, em_fl4, fls4, busy4;
  logic [1:0] fa4, fb4;
  logic [3:0] scnt4, fcnt4;
  int n_chk = 0, n_fail = 0;
  logic armed = 1'b0;
  int age = 1;
  logic m_busy = 1'b0;
  longint stall_m = 0, flush_m = 0;
  logic e_mc, e_done, e_mcs, e_ld, e_pc, e_fd, e_de, e_fdf, e_def, e_emf, e_ls;
  int e_fa, e_fb;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .rs1use_ID(rs1use), .rs2use_ID(rs2use), .rs1_ID(rs1), .rs2_ID(rs2),
    .optype_ID(opid), .rd_EXE(rde), .rd_MEM(rdm), .optype_EXE(ope), .optype_MEM(opm),
    .rs2_EXE(rs2e), .redirect_EXE(redir), .PC_EN_IF(pc_en), .reg_FD_EN(fd_en), .reg_DE_EN(de_en),
    .reg_EM_EN(em_en), .reg_MW_EN(mw_en), .reg_FD_flush(fd_fl), .reg_DE_flush(de_fl),
    .reg_EM_flush(em_fl), .forward_ctrl_A(fa), .forward_ctrl_B(fb), .forward_ctrl_ls(fls),
    .mc_busy(busy), .stall_cnt(scnt), .flush_cnt(fcnt));

  hazard_ctrl_mc #(.REG_AW(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .rs1use_ID(rs1use), .rs2use_ID(rs2use), .rs1_ID(rs1), .rs2_ID(rs2),
    .optype_ID(opid), .rd_EXE(rde), .rd_MEM(rdm), .optype_EXE(ope), .optype_MEM(opm),
    .rs2_EXE(rs2e), .redirect_EXE(redir), .PC_EN_IF(pc_en4), .reg_FD_EN(fd_en4), .reg_DE_EN(de_en4),
    .reg_EM_EN(em_en4), .reg_MW_EN(mw_en4), .reg_FD_flush(fd_fl4), .reg_DE_flush(de_fl4),
    .reg_EM_flush(em_fl4), .forward_ctrl_A(fa4), .forward_ctrl_B(fb4), .forward_ctrl_ls(fls4),
    .mc_busy(busy4), .stall_cnt(scnt4), .flush_cnt(fcnt4));

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fwd_of(input logic use_, input logic [4:0] rs);
    if (!use_ || rs == 5'd0) return 0;
    if (rs == rde && (ope == OP_ALU || e_done)) return 1;
    if (rs == rdm) return (opm == OP_ALU || opm == OP_MUL || opm == OP_DIV) ? 2 : (opm == OP_LOAD) ? 3 : 0;
    return 0;
  endfunction

  // model: an MC op needs LAT cycles in EXE; age counts cycles the current EXE op has been held
  always_comb begin
    e_mc = !rst && (ope == OP_MUL || ope == OP_DIV);
    e_done = e_mc && age >= (ope == OP_MUL ? MUL_LAT : DIV_LAT);
    e_mcs = e_mc && !e_done;
    e_ld = ope == OP_LOAD && rde != 5'd0 &&
           ((rs1use && rs1 == rde) || (rs2use && rs2 == rde && opid != OP_STORE));
    e_pc = 1'b1; e_fd = 1'b1; e_de = 1'b1; e_fdf = 1'b0; e_def = 1'b0; e_emf = 1'b0;
    if (redir) begin
      e_fdf = 1'b1; e_def = 1'b1;
    end else if (e_mcs) begin
      e_pc = 1'b0; e_fd = 1'b0; e_de = 1'b0; e_emf = 1'b1;
    end else if (e_ld) begin
      e_pc = 1'b0; e_fd = 1'b0; e_def = 1'b1;
    end
    e_fa = fwd_of(rs1use, rs1);
    e_fb = fwd_of(rs2use, rs2);
    e_ls = ope == OP_STORE && rs2e != 5'd0 && rs2e == rdm && opm == OP_LOAD;
  end

  always @(posedge clk) begin
    if (rst) begin
      armed <= 1'b1; age <= 1; m_busy <= 1'b0; stall_m <= 0; flush_m <= 0;
    end else if (armed) begin
      age <= e_de ? 1 : age + 1;
      m_busy <= e_mcs;
      stall_m <= stall_m + (e_pc ? 0 : 1);
      flush_m <= flush_m + (redir ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("redir_with_mc", longint'(redir && e_mcs), 0);
      check("pc_en", pc_en, e_pc);
      check("fd_en", fd_en, e_fd);
      check("de_en", de_en, e_de);
      check("em_en", em_en, 1);
      check("mw_en", mw_en, 1);
      check("fd_flush", fd_fl, e_fdf);
      check("de_flush", de_fl, e_def);
      check("em_flush", em_fl, e_emf);
      check("fwd_a", fa, e_fa);
      check("fwd_b", fb, e_fb);
      check("fwd_ls", fls, e_ls);
      check("mc_busy", busy, m_busy);
      check("stall_cnt", scnt, stall_m > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : stall_m);
      check("flush_cnt", fcnt, flush_m > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : flush_m);
      check("stall_cnt4", scnt4, stall_m > 15 ? 15 : stall_m);
      check("flush_cnt4", fcnt4, flush_m > 15 ? 15 : flush_m);
      check("pc_en4", pc_en4, e_pc);
      check("mc_busy4", busy4, m_busy);
    end
  end

  task automatic clear();
    rs1use = 0; rs2use = 0; rs1 = 0; rs2 = 0; opid = OP_NONE; rde = 0; rdm = 0;
    ope = OP_NONE; opm = OP_NONE; rs2e = 0; redir = 0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; clear();
    adv(); adv();
    rst = 0;
  endtask

  initial begin
    clear();
    do_reset();
    @(negedge clk);
    check("rst_stall", scnt, 0); check("rst_flush", fcnt, 0); check("rst_busy", busy, 0);
    // ALU forward from EXE then from MEM
    adv();
    ope = OP_ALU; rde = 5; opid = OP_ALU; rs1use = 1; rs2use = 1; rs1 = 5; rs2 = 5;
    @(negedge clk);
    check("alu_exe_a", fa, 1); check("alu_exe_b", fb, 1); check("alu_no_stall", pc_en, 1);
    adv();
    ope = OP_NONE; rde = 0; opm = OP_ALU; rdm = 5;
    @(negedge clk);
    check("alu_mem_a", fa, 2); check("alu_mem_b", fb, 2);
    adv();
    ope = OP_ALU; rde = 5;
    @(negedge clk);
    check("exe_prio", fa, 1);
    // load-use stall then MEM load forward
    do_reset();
    ope = OP_LOAD; rde = 7; opid = OP_ALU; rs1use = 1; rs1 = 7;
    @(negedge clk);
    check("lu_pc", pc_en, 0); check("lu_deflush", de_fl, 1);
    adv();
    ope = OP_NONE; rde = 0; opm = OP_LOAD; rdm = 7;
    @(negedge clk);
    check("lu_release", pc_en, 1); check("lu_fwd_ld", fa, 3); check("lu_cnt", scnt, 1);
    // load feeding store data: no stall, then ls forward
    do_reset();
    ope = OP_LOAD; rde = 8; opid = OP_STORE; rs1use = 1; rs1 = 2; rs2use = 1; rs2 = 8;
    @(negedge clk);
    check("ls_nostall", pc_en, 1); check("ls_nodeflush", de_fl, 0);
    adv();
    clear(); ope = OP_STORE; rs2e = 8; opm = OP_LOAD; rdm = 8;
    @(negedge clk);
    check("ls_fwd", fls, 1);
    // MUL occupancy, then DIV back-to-back
    do_reset();
    ope = OP_MUL; rde = 9; opid = OP_ALU; rs1use = 1; rs1 = 9;
    @(negedge clk);
    check("mul_c1_pc", pc_en, 0); check("mul_c1_em", em_fl, 1); check("mul_c1_busy", busy, 0);
    adv();
    @(negedge clk);
    check("mul_c2_pc", pc_en, 0); check("mul_c2_busy", busy, 1);
    adv();
    @(negedge clk);
    check("mul_c3_pc", pc_en, 1); check("mul_c3_fwd", fa, 1); check("mul_c3_busy", busy, 1);
    check("mul_cnt", scnt, 2);
    adv();
    clear(); ope = OP_DIV; rde = 10; opm = OP_MUL; rdm = 9;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("div_stall", pc_en, 0);
      adv();
    end
    @(negedge clk);
    check("div_done_pc", pc_en, 1); check("div_cnt", scnt, 9);
    adv();
    clear();
    @(negedge clk);
    check("div_idle", busy, 0);
    // redirect overrides load-use
    do_reset();
    ope = OP_LOAD; rde = 7; opid = OP_ALU; rs1use = 1; rs1 = 7; redir = 1;
    @(negedge clk);
    check("rd_fd", fd_fl, 1); check("rd_de", de_fl, 1); check("rd_pc", pc_en, 1);
    adv();
    clear();
    @(negedge clk);
    check("rd_cnt", fcnt, 1); check("rd_nostall", scnt, 0);
    // reset mid-DIV
    do_reset();
    ope = OP_DIV; rde = 3;
    adv(); adv();
    @(negedge clk);
    check("div_pre_rst_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    check("rst_mc_inactive", pc_en, 1);
    adv();
    rst = 0; clear();
    @(negedge clk);
    check("rst_abort_busy", busy, 0); check("rst_abort_cnt", scnt, 0);
    // saturation on the narrow instance
    do_reset();
    ope = OP_LOAD; rde = 7; rs1use = 1; rs1 = 7;
    repeat (20) adv();
    @(negedge clk);
    check("sat_stall4", scnt4, 15); check("sat_stall32", scnt, 20);
    adv();
    clear(); redir = 1;
    repeat (18) adv();
    @(negedge clk);
    check("sat_flush4", fcnt4, 15); check("sat_flush32", fcnt, 18);
    adv();
    clear();
    adv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Parametrised hazard/forwarding controller for the 5-stage RV32 pipeline (IF/ID/EXE/MEM/WB). It supersedes the single-cycle-EXE hazard unit and adds four things:
- a multi-cycle MUL/DIV occupancy FSM;
- branch/jump redirect flushes;
- load→store data forwarding that removes a class of load-use stalls;
- saturating stall and flush performance counters.
Forwarding is combinational; the occupancy FSM and the counters are registered.

Parameters:
REG_AW, 5, register-address width
MUL_LAT, 3, total EXE-occupancy cycles of a MUL (≥1)
DIV_LAT, 8, total EXE-occupancy cycles of a DIV (≥1)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rs1use_ID, rs2use_ID  in  1 each  ID instruction reads rs1/rs2
rs1_ID, rs2_ID  in  REG_AW each  ID source registers
optype_ID  in  3  ID op class (encoding in package)
rd_EXE, rd_MEM  in  REG_AW each  destinations in EXE/MEM
optype_EXE, optype_MEM  in  3 each  op class in EXE/MEM
rs2_EXE  in  REG_AW  store-data source of the EXE instruction
redirect_EXE  in  1  taken branch / jump resolved in EXE
PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN  out  1 each  stage enables
reg_FD_flush, reg_DE_flush, reg_EM_flush  out  1 each  bubble insert
forward_ctrl_A, forward_ctrl_B  out  2 each  00 regfile, 01 EXE ALU, 10 MEM ALU/MC, 11 MEM load
forward_ctrl_ls  out  1  store data in EXE taken from MEM load data
mc_busy  out  1  FSM not IDLE
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:

Op-class encoding: 000 NONE, 001 ALU, 010 LOAD, 011 BRJ, 100 STORE, 101 MUL, 110 DIV. Op classes 011 and 100 never write rd.

Dependency definitions:
- depX_EXE = rsXuse_ID && rsX_ID≠0 && rsX_ID==rd_EXE.
- depX_MEM is the same test against rd_MEM.

Forwarding (combinational), evaluated per operand; EXE match has priority over MEM match:
- 01 if depX_EXE and EXE is ALU, or EXE is MUL/DIV in its final cycle (mc_done).
- Otherwise 10 if depX_MEM and MEM is ALU/MUL/DIV.
- Otherwise 11 if depX_MEM and MEM is LOAD.
- Otherwise 00.

forward_ctrl_ls = (optype_EXE==STORE) && rs2_EXE≠0 && rs2_EXE==rd_MEM && (optype_MEM==LOAD).

Load-use stall (ld_stall): EXE is LOAD, rd_EXE≠0, and (dep1_EXE or dep2_EXE). Exception: when optype_ID==STORE, a match on rs2 alone does not stall; the store data is resolved later via forward_ctrl_ls.

MC FSM states: IDLE, BUSY.
- IDLE→BUSY when optype_EXE∈{MUL,DIV} and the op is newly entered (not already counted). On entry, cnt loads LAT−2.
- If LAT==1, the FSM stays IDLE and mc_done is asserted in that same cycle.
- In BUSY: cnt decrements each cycle; mc_done=1 when cnt==0, and the FSM then returns to IDLE on the next edge.
- mc_stall = (EXE is MUL/DIV) && !mc_done.
- Back-to-back MUL/DIV: IDLE re-entry is gated by a registered "EXE op already accepted" flag, which is cleared when reg_DE_EN advances EXE.

Control outputs. Defaults: all enables 1, all flushes 0. Priority, highest first:
1. redirect_EXE → reg_FD_flush=1, reg_DE_flush=1, PC_EN_IF=1. This overrides ld_stall.
2. mc_stall → PC_EN_IF=0, reg_FD_EN=0, reg_DE_EN=0, reg_EM_flush=1 (bubble into MEM).
3. ld_stall → PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1.

A redirect cannot coincide with mc_stall, because EXE holds a single op. The bench asserts this never occurs.

Counters:
- stall_cnt increments on each cycle with PC_EN_IF==0.
- flush_cnt increments on each cycle with redirect_EXE==1.
- Both saturate at all-ones and never wrap.

Reset:
- rst=1 forces FSM IDLE, cnt=0, accepted flag 0, stall_cnt=0, flush_cnt=0, and mc_busy=0 in the following cycle.
- A reset in mid-BUSY aborts the op.
- The combinational outputs during rst follow the same rules, with the MC terms forced inactive.

Decomposition:
- Package hazard_pkg holds: the op-class constants (OP_NONE … OP_DIV), the forwarding-select constants FWD_RF/FWD_EXE/FWD_MEM/FWD_LD, and the FSM state typedef.
- One sub-module is natural: mc_occupancy (FSM + down-counter + accepted flag, outputs mc_stall/mc_done/mc_busy).

Test Plan:
- ALU x5 in EXE, ID add x6,x5,x5 → forward_ctrl_A=B=01, no stall; same op one stage later in MEM → 10/10.
- LOAD x7 in EXE, ID uses rs1=x7 → PC_EN_IF=0, reg_DE_flush=1 for exactly 1 cycle, stall_cnt +1. Next cycle with MEM=LOAD x7 → forward_ctrl_A=11.
- LOAD x8 in EXE, ID store with rs2=x8 (rs1=x2) → no stall. Next cycle: forward_ctrl_ls=1.
- MUL x9 enters EXE with MUL_LAT=3 → PC_EN_IF=0 and reg_EM_flush=1 for 2 cycles, mc_busy=1 for 2 cycles, mc_done in cycle 3 with forward 01 to a dependent ID op; stall_cnt +2. Then DIV immediately after → 7 stall cycles.
- redirect_EXE=1 while LOAD-use would stall → reg_FD_flush=reg_DE_flush=1, PC_EN_IF=1, flush_cnt +1.
- rst asserted in 2nd BUSY cycle of a DIV → next cycle mc_busy=0, counters 0. Separately, preload stall_cnt near all-ones (CNT_W=4) → holds at 15.
